data_memory_wait: RTL and testbench
===================================

# data_memory_wait

Parametrised, clocked data memory for the MIPS datapath. It replaces the fixed-width, zero-latency data memory with a configurable width/depth array, a programmable wait-state access FSM with a one-cycle `ready` response, and sub-word (byte/halfword) loads and stores with sign/zero extension and misalignment detection. It sits behind the MEM stage; the pipeline stalls from request acceptance until `ready` pulses.

## Interface
- `DATA_WIDTH`, default 32: word width in bits; power of two, multiple of 8, ≥32.
- `DEPTH`, default 256: number of words; power of two.
- `ADDR_WIDTH`, default 32: byte-address width.
- `WAIT_CYCLES`, default 2: extra wait states before the array access; 0 is legal.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in ADDR_WIDTH: byte address.
- `writedata` in DATA_WIDTH: store data, right-aligned for sub-word stores.
- `MemWrite` in 1: store request.
- `MemRead` in 1: load request.
- `size` in 2: 00 = byte, 01 = halfword, 10 = full word; 11 is treated as full word.
- `sign_ext` in 1: sign-extend sub-word loads when 1, zero-extend when 0.
- `readdata` out DATA_WIDTH: load result, registered.
- `ready` out 1: one-cycle completion pulse.
- `misaligned` out 1: error flag, valid while `ready` is high.

## Operation
- Lanes: `BYTES = DATA_WIDTH/8`. Byte offset is `addr[log2(BYTES)-1:0]`. Word index is the next `log2(DEPTH)` bits. Higher address bits are ignored, so out-of-range addresses wrap modulo DEPTH.
- Byte order is little-endian: byte 0 occupies bits [7:0].
- FSM states are IDLE, BUSY and RESP.
  - IDLE: if `MemWrite` or `MemRead` is high at an edge, latch `addr`, `writedata`, `size`, `sign_ext` and the operation, load `cnt = WAIT_CYCLES`, and go to BUSY. If both are high, it is a write; the read is dropped.
  - BUSY: if `cnt != 0`, decrement. If `cnt == 0`, perform the access and go to RESP.
  - RESP: `ready` = 1 for this cycle; the next edge returns to IDLE.
- Requests arriving while in BUSY or RESP are ignored; they are not queued.
- Store: write only the addressed lanes (1, 2 or BYTES lanes). All other bits of the word are preserved.
- Load: extract the addressed byte or halfword, extend it according to `sign_ext`, and place the result in `readdata`. A full-word load returns the whole word.
- Misalignment:
  - A halfword with `addr[0] = 1` is misaligned.
  - A full word with a nonzero byte offset is misaligned.
  - On a misaligned access, memory is unchanged, `readdata` is unchanged, and `misaligned = 1` with the `ready` pulse.
- After a store, `readdata` holds its previous value. `readdata` otherwise holds until the next load completes.

## Timing
- Reset values: state = IDLE, `cnt = 0`, `ready = 0`, `misaligned = 0`, `readdata = 0`, all memory words = 0.
- Latency: for a request sampled at edge N, the array is accessed at edge N+1+WAIT_CYCLES.
- `ready` and `misaligned` are registered. They are high from edge N+1+WAIT_CYCLES to edge N+2+WAIT_CYCLES.
- Maximum throughput is one access per WAIT_CYCLES+3 edges.
- `misaligned` is 0 whenever `ready` is 0.
- Reset during BUSY or RESP aborts the operation:
  - No `ready` pulse is produced.
  - An uncommitted store is lost.
  - Memory is cleared regardless.
- Request inputs need only be valid at the accepting edge.

## Configuration
- `DMEM_SUBWORD_EN` defined: byte/halfword accesses and `sign_ext` behave as described above.
- `DMEM_SUBWORD_EN` undefined:
  - `size` and `sign_ext` are ignored and every access is full-word.
  - `misaligned` is set iff the byte offset is nonzero.
  - The lane-merge and extension logic is not built.

## Test plan
Settings: DATA_WIDTH=32, DEPTH=64, WAIT_CYCLES=2, `DMEM_SUBWORD_EN` defined.
- Pulse `rst`, then load word at addr 40 → `ready` pulses exactly 3 edges after acceptance, `readdata` = 0, `misaligned` = 0.
- Store word 0x12345678 at addr 20, then load word at addr 20 → `readdata` = 0x12345678. During the store's response, `readdata` holds its prior value.
- Store byte 0xAB at addr 21, then load word at addr 20 → 0x1234AB78.
  - Load byte at addr 21 with `sign_ext` = 1 → 0xFFFFFFAB.
  - Same load with `sign_ext` = 0 → 0x000000AB.
  - Load halfword at addr 22 with `sign_ext` = 1 → 0x00001234.
- Load halfword at addr 23 → `misaligned` = 1 with `ready`, `readdata` unchanged. Store word 77 at addr 22 → `misaligned` = 1; a word load at addr 20 still returns 0x1234AB78.
- Store word 77 at addr 4 and assert `rst` during BUSY → no `ready` pulse. After reset, a word load at addr 4 returns 0.
- Store word 333 at addr 256, which wraps to word 0. A word load at addr 0 returns 333. Asserting `MemRead` and `MemWrite` together at addr 8 with data 5 performs the write, and a later load at addr 8 returns 5.

Source files
------------

// File: rtl/data_memory_wait_if.sv
// Request/response bus between the MEM stage and data_memory_wait.
// The master drives the request fields; the memory returns readdata/ready/misaligned.
interface data_memory_wait_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  MemWrite;
    logic                  MemRead;
    logic [1:0]            size;
    logic                  sign_ext;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  ready;
    logic                  misaligned;

    modport master (
        output addr, writedata, MemWrite, MemRead, size, sign_ext,
        input  readdata, ready, misaligned
    );

    modport slave (
        input  addr, writedata, MemWrite, MemRead, size, sign_ext,
        output readdata, ready, misaligned
    );
endinterface

// File: rtl/data_memory_wait.sv
// Wait-state data memory with a one-cycle ready pulse. Byte/halfword accesses with
// sign/zero extension are built only when DMEM_SUBWORD_EN is defined; otherwise all accesses are full-word.
module data_memory_wait #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_wait_if.slave   bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_q;
    logic [OFF_W-1:0]      off_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] readdata_q;
    logic                  ready_q;
    logic                  mis_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  access;
    logic                  mis_c;
    logic [DATA_WIDTH-1:0] word_rd;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] wlanes;
    logic [DATA_WIDTH-1:0] word_wr;
    logic [DATA_WIDTH-1:0] load_c;

    // Address bits above the word index are don't-care: addresses wrap modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^bus.addr[ADDR_WIDTH-1:OFF_W+IDX_W];

    assign word_rd = mem[idx_q];

`ifdef DMEM_SUBWORD_EN
    logic [1:0] size_q;
    logic       sext_q;
    logic       is_byte;
    logic       is_half;

    function automatic logic [DATA_WIDTH-1:0] ext_byte(input logic [7:0] b, input logic sx);
        logic signed [7:0]            sb;
        logic signed [DATA_WIDTH-1:0] s;
        sb = b;
        s  = sb;
        return sx ? s : {{(DATA_WIDTH-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ext_half(input logic [15:0] h, input logic sx);
        logic signed [15:0]           sh;
        logic signed [DATA_WIDTH-1:0] s;
        sh = h;
        s  = sh;
        return sx ? s : {{(DATA_WIDTH-16){1'b0}}, h};
    endfunction

    assign is_byte = (size_q == 2'b00);
    assign is_half = (size_q == 2'b01);
    assign mis_c   = (is_half && off_q[0]) || (!is_byte && !is_half && (off_q != '0));

    // Lane steering: byte data sits in bits [7:0], halfword data in [15:0] of writedata.
    always_comb begin
        wmask  = '0;
        wlanes = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (is_byte) begin
                wmask[8*i +: 8]  = (OFF_W'(i) == off_q) ? 8'hFF : 8'h00;
                wlanes[8*i +: 8] = wdata_q[7:0];
            end else if (is_half) begin
                wmask[8*i +: 8]  = ((OFF_W'(i) >> 1) == (off_q >> 1)) ? 8'hFF : 8'h00;
                wlanes[8*i +: 8] = wdata_q[8*(i%2) +: 8];
            end else begin
                wmask[8*i +: 8]  = 8'hFF;
                wlanes[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        if (is_byte)
            load_c = ext_byte(word_rd[{off_q, 3'b000} +: 8], sext_q);
        else if (is_half)
            load_c = ext_half(word_rd[{off_q[OFF_W-1:1], 4'b0000} +: 16], sext_q);
        else
            load_c = word_rd;
    end
`else
    logic unused_sub;
    assign unused_sub = ^{bus.size, bus.sign_ext};

    assign mis_c  = (off_q != '0);
    assign wmask  = '1;
    assign wlanes = wdata_q;
    assign load_c = word_rd;
`endif

    assign word_wr = (word_rd & ~wmask) | (wlanes & wmask);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MemWrite || bus.MemRead) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            off_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
            ready_q    <= 1'b0;
            mis_q      <= 1'b0;
`ifdef DMEM_SUBWORD_EN
            size_q     <= 2'b10;
            sext_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= access;
            mis_q   <= access && mis_c;
            if (accept) begin
                cnt_q   <= CNT_INIT;
                wr_q    <= bus.MemWrite;
                off_q   <= bus.addr[OFF_W-1:0];
                idx_q   <= bus.addr[OFF_W +: IDX_W];
                wdata_q <= bus.writedata;
`ifdef DMEM_SUBWORD_EN
                size_q  <= bus.size;
                sext_q  <= bus.sign_ext;
`endif
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (access && !mis_c && !wr_q)
                readdata_q <= load_c;
        end
    end

    // Array is cleared on reset, so a store aborted by reset never lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '{default: '0};
        else if (access && !mis_c && wr_q)
            mem[idx_q] <= word_wr;
    end

    assign bus.readdata   = readdata_q;
    assign bus.ready      = ready_q;
    assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_data_memory_wait.sv
// Directed bench for data_memory_wait (DATA_WIDTH=32, DEPTH=64, WAIT_CYCLES=2).
// Expectations follow the DMEM_SUBWORD_EN setting of the build.
module tb_data_memory_wait;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

`ifdef DMEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    data_memory_wait_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_memory_wait #(
        .DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(32), .WAIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One request accepted at edge N; checks latency, result, flag and the single-cycle pulse.
    task automatic op(input string tag, input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] sz, input logic sx,
                      input logic [31:0] exp_rd, input logic exp_mis);
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        @(negedge clk);
        bus.MemWrite  = wr;
        bus.MemRead   = rd;
        bus.addr      = a;
        bus.writedata = d;
        bus.size      = sz;
        bus.sign_ext  = sx;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.addr      = 32'hFFFF_FFFF;
        bus.writedata = 32'hDEAD_BEEF;
        bus.size      = 2'b11;
        bus.sign_ext  = ~sx;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                lat = k;
                break;
            end
        end
        rdata = bus.readdata;
        mis   = bus.misaligned;
        chk({tag, "_latency"}, lat, 32'd3);
        chk({tag, "_readdata"}, rdata, exp_rd);
        chk({tag, "_misaligned"}, {31'd0, mis}, {31'd0, exp_mis});
        @(posedge clk);
        #1;
        chk({tag, "_ready_drop"}, {31'd0, bus.ready}, 32'd0);
        chk({tag, "_mis_drop"}, {31'd0, bus.misaligned}, 32'd0);
    endtask

    initial begin
        logic [31:0] w20;
        logic [31:0] prev;
        logic        seen;

        rst           = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.addr      = '0;
        bus.writedata = '0;
        bus.size      = 2'b10;
        bus.sign_ext  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        chk("reset_misaligned", {31'd0, bus.misaligned}, 32'd0);
        chk("reset_readdata", bus.readdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op("ld40", 1'b0, 1'b1, 32'd40, 32'd0, 2'b10, 1'b0, 32'd0, 1'b0);
        op("sw20", 1'b1, 1'b0, 32'd20, 32'h1234_5678, 2'b10, 1'b0, 32'd0, 1'b0);
        op("lw20", 1'b0, 1'b1, 32'd20, 32'd0, 2'b10, 1'b0, 32'h1234_5678, 1'b0);
        op("sb21", 1'b1, 1'b0, 32'd21, 32'h0000_00AB, 2'b00, 1'b0, 32'h1234_5678, !SUB);

        w20 = SUB ? 32'h1234_AB78 : 32'h1234_5678;
        op("lw20_after_sb", 1'b0, 1'b1, 32'd20, 32'd0, 2'b10, 1'b0, w20, 1'b0);
        op("lb21_sext", 1'b0, 1'b1, 32'd21, 32'd0, 2'b00, 1'b1, SUB ? 32'hFFFF_FFAB : w20, !SUB);
        op("lb21_zext", 1'b0, 1'b1, 32'd21, 32'd0, 2'b00, 1'b0, SUB ? 32'h0000_00AB : w20, !SUB);
        op("lh22_sext", 1'b0, 1'b1, 32'd22, 32'd0, 2'b01, 1'b1, SUB ? 32'h0000_1234 : w20, !SUB);

        prev = SUB ? 32'h0000_1234 : w20;
        op("lh23_misal", 1'b0, 1'b1, 32'd23, 32'd0, 2'b01, 1'b1, prev, 1'b1);
        op("sw22_misal", 1'b1, 1'b0, 32'd22, 32'd77, 2'b10, 1'b0, prev, 1'b1);
        op("lw20_intact", 1'b0, 1'b1, 32'd20, 32'd0, 2'b10, 1'b0, w20, 1'b0);

        // Store to addr 4 aborted by reset one edge into BUSY.
        @(negedge clk);
        bus.MemWrite  = 1'b1;
        bus.addr      = 32'd4;
        bus.writedata = 32'd77;
        bus.size      = 2'b10;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_readdata_cleared", bus.readdata, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen = seen | bus.ready;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | bus.ready;
        end
        chk("abort_no_ready", {31'd0, seen}, 32'd0);

        op("sw8", 1'b1, 1'b0, 32'd8, 32'h0000_0055, 2'b10, 1'b0, 32'd0, 1'b0);
        op("lw8", 1'b0, 1'b1, 32'd8, 32'd0, 2'b10, 1'b0, 32'h0000_0055, 1'b0);
        op("lw4_lost", 1'b0, 1'b1, 32'd4, 32'd0, 2'b10, 1'b0, 32'd0, 1'b0);
        op("sw256_wrap", 1'b1, 1'b0, 32'd256, 32'd333, 2'b10, 1'b0, 32'd0, 1'b0);
        op("lw0_wrap", 1'b0, 1'b1, 32'd0, 32'd0, 2'b10, 1'b0, 32'd333, 1'b0);
        op("lw20_cleared", 1'b0, 1'b1, 32'd20, 32'd0, 2'b10, 1'b0, 32'd0, 1'b0);
        op("rw8_both", 1'b1, 1'b1, 32'd8, 32'd5, 2'b10, 1'b0, 32'd0, 1'b0);
        op("lw8_both", 1'b0, 1'b1, 32'd8, 32'd0, 2'b10, 1'b0, 32'd5, 1'b0);

        op("sh10", 1'b1, 1'b0, 32'd10, 32'h0000_8001, 2'b01, 1'b0, 32'd5, !SUB);
        op("lw8_after_sh", 1'b0, 1'b1, 32'd8, 32'd0, 2'b10, 1'b0,
           SUB ? 32'h8001_0005 : 32'd5, 1'b0);
        op("lh10_sext", 1'b0, 1'b1, 32'd10, 32'd0, 2'b01, 1'b1,
           SUB ? 32'hFFFF_8001 : 32'd5, !SUB);
        op("lh10_zext", 1'b0, 1'b1, 32'd10, 32'd0, 2'b01, 1'b0,
           SUB ? 32'h0000_8001 : 32'd5, !SUB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
